// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-master data memory arbiter.
package dmem_arb_pkg;

    // Sequencer states: accept a request, strobe the memory, return the response.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int MEM_DEPTH_DEFAULT = 256;

    // Latched command of the granted master, held for ISSUE and RESP.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        id;     // granted master
        logic        legal;  // aligned and in range
    } cmd_t;

    // A word access is legal when word-aligned and inside the memory.
    function automatic logic addr_legal(input logic [31:0] addr, input int unsigned depth);
        logic [33:0] limit;
        limit = 34'(depth) << 2;
        return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-request picker: a lone request wins; ties go to master 0 under fixed
// priority, otherwise to the master that was not granted last time.
module rr_pick2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant,
    output logic valid
);

    // Combinational grant selection.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        valid = req0 | req1;
        grant = 1'b0;
        if (req0 && req1) begin
            grant = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
        end else if (req1) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-master arbiter and sequencer in front of a single-port synchronous data
// memory. Each transaction takes IDLE -> ISSUE -> RESP; memory-side outputs are
// register-driven, only mem_data_i passes combinationally to the read data.
module data_memory_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_DEPTH  = MEM_DEPTH_DEFAULT,
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_data_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_data_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        mem_write_o,
    output logic        mem_read_o,
    input  logic [31:0] mem_data_i
);

    state_t state_q, state_d;
    cmd_t   cmd_q, cmd_d;
    logic   last_grant_q;
    logic   pick_grant, pick_valid;

    rr_pick2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .req0       (m0_req_i),
        .req1       (m1_req_i),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    // Command of the winning master, captured when leaving IDLE.
    always_comb begin
        cmd_d.id    = pick_grant;
        cmd_d.we    = pick_grant ? m1_we_i   : m0_we_i;
        cmd_d.addr  = pick_grant ? m1_addr_i : m0_addr_i;
        cmd_d.data  = pick_grant ? m1_data_i : m0_data_i;
        cmd_d.legal = addr_legal(cmd_d.addr, MEM_DEPTH);
    end

    // Next-state logic of the transaction sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_valid) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register, command latch and round-robin history.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pick_valid) begin
                cmd_q <= cmd_d;
            end
            if (state_q == RESP) begin
                last_grant_q <= cmd_q.id;
            end
        end
    end

    // Memory strobes in ISSUE and the response demux in RESP.
    always_comb begin
        mem_addr_o  = cmd_q.addr;
        mem_data_o  = cmd_q.data;
        mem_write_o = 1'b0;
        mem_read_o  = 1'b0;
        m0_ack_o    = 1'b0;
        m0_err_o    = 1'b0;
        m0_data_o   = '0;
        m1_ack_o    = 1'b0;
        m1_err_o    = 1'b0;
        m1_data_o   = '0;
        if (state_q == ISSUE && cmd_q.legal) begin
            mem_write_o = cmd_q.we;
            mem_read_o  = ~cmd_q.we;
        end
        if (state_q == RESP) begin
            if (cmd_q.id) begin
                m1_ack_o  = 1'b1;
                m1_err_o  = ~cmd_q.legal;
                m1_data_o = (cmd_q.legal && !cmd_q.we) ? mem_data_i : '0;
            end else begin
                m0_ack_o  = 1'b1;
                m0_err_o  = ~cmd_q.legal;
                m0_data_o = (cmd_q.legal && !cmd_q.we) ? mem_data_i : '0;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: a round-robin instance wired to a
// 256-word synchronous memory model, plus a fixed-priority instance on the
// same request inputs for tie behaviour.
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read;

    logic        fp_m0_ack, fp_m0_err, fp_m1_ack, fp_m1_err;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_mem_addr, fp_mem_wdata;
    logic        fp_mem_write, fp_mem_read;
    logic [31:0] fp_mem_rdata = 32'h0;

    logic [31:0] mem [256];
    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_val;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    data_memory_arbiter #(.MEM_DEPTH(256), .FIXED_PRIO(0)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_data_i(m0_wdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_data_i(m1_wdata),
        .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_data_o(m0_rdata),
        .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_data_o(m1_rdata),
        .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
        .mem_write_o(mem_write), .mem_read_o(mem_read), .mem_data_i(mem_rdata)
    );

    data_memory_arbiter #(.MEM_DEPTH(256), .FIXED_PRIO(1)) u_fp (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_data_i(m0_wdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_data_i(m1_wdata),
        .m0_ack_o(fp_m0_ack), .m0_err_o(fp_m0_err), .m0_data_o(fp_m0_rdata),
        .m1_ack_o(fp_m1_ack), .m1_err_o(fp_m1_err), .m1_data_o(fp_m1_rdata),
        .mem_addr_o(fp_mem_addr), .mem_data_o(fp_mem_wdata),
        .mem_write_o(fp_mem_write), .mem_read_o(fp_mem_read), .mem_data_i(fp_mem_rdata)
    );

    // Single-port synchronous memory: write commits and read data registers at the strobe edge.
    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_val;
        if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
        if (mem_read) mem_rdata <= mem[mem_addr[9:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] data);
        m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = data;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] data);
        m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = data;
    endtask

    initial begin
        rst = 1'b1;
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        mem_rdata = 32'h0;
        pre_we = 1'b1; pre_idx = 8'd4;  pre_val = 32'hDEADBEEF;
        step();
        pre_idx = 8'd0;  pre_val = 32'hA5A5A5A5;
        step();
        pre_idx = 8'd12; pre_val = 32'h00000000;
        step();
        pre_we = 1'b0;

        // Reset values
        check("rst_m0_ack",   {31'b0, m0_ack},    32'h0);
        check("rst_m1_ack",   {31'b0, m1_ack},    32'h0);
        check("rst_m0_err",   {31'b0, m0_err},    32'h0);
        check("rst_m0_data",  m0_rdata,           32'h0);
        check("rst_m1_data",  m1_rdata,           32'h0);
        check("rst_strobes",  {30'b0, mem_write, mem_read}, 32'h0);
        check("rst_mem_addr", mem_addr,           32'h0);
        check("rst_mem_data", mem_wdata,          32'h0);
        rst = 1'b0;
        step();

        // m0 reads word 4
        set_m0(1'b1, 1'b0, 32'h10, 32'h0);
        step();
        check("rd_issue_read",  {31'b0, mem_read},  32'h1);
        check("rd_issue_write", {31'b0, mem_write}, 32'h0);
        check("rd_issue_addr",  mem_addr,           32'h10);
        check("rd_issue_noack", {31'b0, m0_ack},    32'h0);
        step();
        check("rd_resp_ack",    {31'b0, m0_ack},    32'h1);
        check("rd_resp_data",   m0_rdata,           32'hDEADBEEF);
        check("rd_resp_err",    {31'b0, m0_err},    32'h0);
        check("rd_resp_nostb",  {31'b0, mem_read},  32'h0);
        check("rd_resp_m1ack",  {31'b0, m1_ack},    32'h0);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("rd_idle_ack",    {31'b0, m0_ack},    32'h0);
        check("rd_idle_data",   m0_rdata,           32'h0);

        // m1 writes 0x20 then reads it back
        set_m1(1'b1, 1'b1, 32'h20, 32'h12345678);
        step();
        check("wr_issue_write", {31'b0, mem_write}, 32'h1);
        check("wr_issue_read",  {31'b0, mem_read},  32'h0);
        check("wr_issue_addr",  mem_addr,           32'h20);
        check("wr_issue_data",  mem_wdata,          32'h12345678);
        step();
        check("wr_resp_ack",    {31'b0, m1_ack},    32'h1);
        check("wr_resp_data",   m1_rdata,           32'h0);
        check("wr_resp_err",    {31'b0, m1_err},    32'h0);
        check("wr_resp_m0ack",  {31'b0, m0_ack},    32'h0);
        set_m1(1'b1, 1'b0, 32'h20, 32'h0);
        step();
        check("rb_idle_ack",    {31'b0, m1_ack},    32'h0);
        step();
        check("rb_issue_read",  {31'b0, mem_read},  32'h1);
        step();
        check("rb_resp_ack",    {31'b0, m1_ack},    32'h1);
        check("rb_resp_data",   m1_rdata,           32'h12345678);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // Misaligned read
        set_m0(1'b1, 1'b0, 32'h3, 32'h0);
        step();
        check("mis_issue_strb", {30'b0, mem_write, mem_read}, 32'h0);
        step();
        check("mis_resp_ack",   {31'b0, m0_ack},    32'h1);
        check("mis_resp_err",   {31'b0, m0_err},    32'h1);
        check("mis_resp_data",  m0_rdata,           32'h0);

        // Out-of-range write
        set_m0(1'b1, 1'b1, 32'h400, 32'hCAFEF00D);
        step();
        check("oor_idle_ack",   {31'b0, m0_ack},    32'h0);
        check("oor_idle_err",   {31'b0, m0_err},    32'h0);
        step();
        check("oor_issue_strb", {30'b0, mem_write, mem_read}, 32'h0);
        step();
        check("oor_resp_ack",   {31'b0, m0_ack},    32'h1);
        check("oor_resp_err",   {31'b0, m0_err},    32'h1);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("oor_mem0_kept",  mem[0],             32'hA5A5A5A5);

        // Last legal word
        set_m0(1'b1, 1'b1, 32'h3FC, 32'h0BADF00D);
        step();
        check("top_issue_write", {31'b0, mem_write}, 32'h1);
        step();
        check("top_resp_ack",   {31'b0, m0_ack},    32'h1);
        check("top_resp_err",   {31'b0, m0_err},    32'h0);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("top_mem255",     mem[255],           32'h0BADF00D);

        // Reset during ISSUE of a write
        set_m0(1'b1, 1'b1, 32'h30, 32'h11112222);
        step();
        check("mid_issue_write", {31'b0, mem_write}, 32'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_strb",   {30'b0, mem_write, mem_read}, 32'h0);
        check("mid_rst_addr",   mem_addr,           32'h0);
        check("mid_rst_data",   mem_wdata,          32'h0);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("mid_rst_noack",  {31'b0, m0_ack},    32'h0);
        check("mid_mem12_kept", mem[12],            32'h0);
        #2;
        rst = 1'b0;

        // Continuous tie: round-robin alternates m0, m1; fixed priority always m0
        set_m0(1'b1, 1'b0, 32'h10, 32'h0);
        set_m1(1'b1, 1'b0, 32'h20, 32'h0);
        for (int c = 1; c <= 12; c++) begin
            step();
            check($sformatf("tie_m0_ack_c%0d", c), {31'b0, m0_ack}, {31'b0, (c % 6) == 2});
            check($sformatf("tie_m1_ack_c%0d", c), {31'b0, m1_ack}, {31'b0, (c % 6) == 5});
            check($sformatf("tie_strb_c%0d", c), {31'b0, mem_write & mem_read}, 32'h0);
            check($sformatf("fp_m0_ack_c%0d", c), {31'b0, fp_m0_ack}, {31'b0, (c % 3) == 2});
            check($sformatf("fp_m1_ack_c%0d", c), {31'b0, fp_m1_ack}, 32'h0);
            if (m0_ack) check($sformatf("tie_m0_data_c%0d", c), m0_rdata, 32'hDEADBEEF);
            if (m1_ack) check($sformatf("tie_m1_data_c%0d", c), m1_rdata, 32'h12345678);
        end
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();
        step();
        check("end_m0_ack", {31'b0, m0_ack}, 32'h0);
        check("end_m1_ack", {31'b0, m1_ack}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-master arbiter and sequencer in front of the single-port, 256-word synchronous data memory. Master 0 is the CPU MEM stage; master 1 is a secondary agent (program loader / DMA / debug). The block serialises their accesses, range- and alignment-checks addresses, drives the memory's write/read strobes, and returns read data with a one-cycle acknowledge per transaction.

## Interface
- `MEM_DEPTH`, 256: memory depth in 32-bit words. Legal byte addresses are 0 .. 4*MEM_DEPTH-4.
- `FIXED_PRIO`, 0: 0 = round-robin between masters; 1 = master 0 always wins ties.

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `m0_req_i`, `m1_req_i`  in  1  request; held high with command stable until ack.
- `m0_we_i`, `m1_we_i`  in  1  1 = write, 0 = read.
- `m0_addr_i`, `m1_addr_i`  in  32  byte address.
- `m0_data_i`, `m1_data_i`  in  32  write data.
- `m0_ack_o`, `m1_ack_o`  out  1  one-cycle completion pulse.
- `m0_err_o`, `m1_err_o`  out  1  valid with ack; 1 = misaligned or out-of-range, no memory access.
- `m0_data_o`, `m1_data_o`  out  32  read data, valid with ack; 0 otherwise.
- `mem_addr_o`  out  32  address to memory (byte address, unchanged).
- `mem_data_o`  out  32  write data to memory.
- `mem_write_o`, `mem_read_o`  out  1  memory strobes.
- `mem_data_i`  in  32  memory read data, registered by memory at the strobe edge.

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state IDLE.
- IDLE: if any req high, pick winner, latch its we/addr/data and the grant id, go ISSUE; otherwise stay.
- Pick: one request → it wins. Both → FIXED_PRIO=1: master 0; FIXED_PRIO=0: the master not granted last. `last_grant` resets to 1, so master 0 wins the first tie.
- ISSUE: drive latched address/data on `mem_addr_o`/`mem_data_o`. Legal access → `mem_write_o` = we, `mem_read_o` = !we. Illegal (addr[1:0] != 0 or addr >= 4*MEM_DEPTH) → both strobes 0. Go RESP.
- RESP: pulse granted master's ack. Legal read → `mX_data_o` = `mem_data_i`; write or error → `mX_data_o` = 0; `mX_err_o` per check. Update `last_grant`. Go IDLE.
- Non-granted master's ack/err/data stay 0 throughout.
- A req still high in the IDLE cycle after ack is a new request.
- Strobes never both high. Strobes are high only in ISSUE.

## Timing
- Reset values: all `mX_ack_o`, `mX_err_o`, `mX_data_o`, `mem_write_o`, `mem_read_o` = 0. `mem_addr_o`, `mem_data_o` = 0. `last_grant` = 1. State IDLE.
- Req sampled at edge k (IDLE) → ISSUE in cycle k+1. The memory commits the write or registers the read at edge k+2. Ack and data arrive in cycle k+2.
- Fixed latency is 2 cycles from sampling edge to ack. Throughput is one transaction per 3 cycles. Error transactions have the same latency.
- A request arriving while the FSM is busy waits. Its req must stay high; no starvation under round-robin: the loser of a tie wins the next tie.
- Reset mid-transaction: outputs drop to reset values immediately (async); the in-flight transaction is lost and no ack is given. If edge k+2 already passed, the memory write is committed.
- The memory/mux addresses are all driven from registers; the only combinational path is `mem_data_i` → `mX_data_o` in RESP.

## Structure
- Package `dmem_arb_pkg`: state enum (IDLE/ISSUE/RESP), `MEM_DEPTH_DEFAULT` = 256, legality-check function (alignment + range).
- Sub-module `rr_pick2`: two-request picker with `last_grant` input and `FIXED_PRIO` parameter; combinational, output grant id and valid.
- Top: FSM, command latch, `last_grant` register, response demux.

## Test plan
- Single read: preload memory[4] = 0xDEADBEEF; m0 reads addr 0x10 → `mem_read_o` high one cycle; `m0_ack_o` in k+2 with `m0_data_o` = 0xDEADBEEF, err 0.
- Write then read: m1 writes 0x12345678 to 0x20, then reads 0x20 → first ack with data 0, second ack returns 0x12345678.
- Tie, round-robin: m0 and m1 both request continuously → grants after reset are m0, m1, m0, m1; each ack 3 cycles apart. With FIXED_PRIO=1 → m0 every time, m1 never while m0 holds req.
- Errors: m0 reads 0x3 → no strobe, ack with err 1, data 0. m0 writes 0x400 (MEM_DEPTH=256) → no `mem_write_o`, err 1, memory unchanged.
- Reset mid-op: assert `rst_i` during ISSUE of a write → all outputs 0 the same cycle, no ack, state IDLE, `last_grant` = 1. After release, m0 wins the next tie.
